// File: rtl/nem_ohmux_pkg.sv
// Shared types and helpers for the NEM one-hot mux select controller.
package nem_ohmux_pkg;
  localparam int N_IN = 4;

  typedef logic [N_IN-1:0] sel_t;
  typedef logic [1:0]      idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENGAGE,
    ST_GRANTED,
    ST_RELEASE,
    ST_PARKED
  } state_t;

  function automatic sel_t onehot(input idx_t i);
    sel_t r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic idx_t oh2idx(input sel_t oh);
    idx_t r;
    r = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (oh[k]) r = idx_t'(k);
    end
    return r;
  endfunction
endpackage

// File: rtl/nem_ohmux_sel_ctrl_if.sv
// Requester-side bundle of the NEM mux select controller: requests in, selects/grants/status out.
interface nem_ohmux_sel_ctrl_if
  import nem_ohmux_pkg::*;
#(
  parameter int CNT_W = 16
);
  sel_t             REQ;
  sel_t             S;
  sel_t             GNT;
  logic             BUSY;
  logic [CNT_W-1:0] ACT_CNT;

  modport master (output REQ, input S, GNT, BUSY, ACT_CNT);
  modport slave  (input REQ, output S, GNT, BUSY, ACT_CNT);
endinterface

// File: rtl/nem_rr_arb.sv
// Combinational 4-way round-robin arbiter; the lowest offset from ptr with a request wins.
module nem_rr_arb
  import nem_ohmux_pkg::*;
(
  input  sel_t req,
  input  idx_t ptr,
  output logic vld,
  output idx_t win
);
  idx_t c;

  // Scan from the far end so the closest candidate to ptr is the last assignment.
  always_comb begin
    vld = 1'b0;
    win = ptr;
    c   = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      c = ptr + idx_t'(k);
      if (req[c]) begin
        vld = 1'b1;
        win = c;
      end
    end
  end
endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make select sequencer and round-robin arbiter for the 4-input NEM one-hot mux.
// Optional holder parking (relay left closed while idle) is built in with `define NEM_PARK_EN.
module nem_ohmux_sel_ctrl
  import nem_ohmux_pkg::*;
#(
  parameter int T_OFF    = 3,
  parameter int T_ON     = 5,
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 16
) (
  input logic                 CP,
  input logic                 RN,
  nem_ohmux_sel_ctrl_if.slave bus
);
  localparam int TMR_A   = (T_OFF > T_ON) ? T_OFF : T_ON;
  localparam int TMR_MAX = (TMR_A > MAX_HOLD) ? TMR_A : MAX_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TOFF_END = TMR_W'(T_OFF - 1);
  localparam logic [TMR_W-1:0] TON_END  = TMR_W'(T_ON - 1);
  localparam logic [TMR_W-1:0] HOLD_END = TMR_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t           state_q, state_d;
  sel_t             s_q, s_d;
  sel_t             gnt_q, gnt_d;
  idx_t             win_q, win_d;
  idx_t             ptr_q, ptr_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic arb_vld;
  idx_t arb_win;
  logic holder_req, others, preempt, start, rel;

  nem_rr_arb u_arb (
    .req (bus.REQ),
    .ptr (ptr_q),
    .vld (arb_vld),
    .win (arb_win)
  );

  assign holder_req = bus.REQ[win_q];
  assign others     = |(bus.REQ & ~onehot(win_q));
  assign preempt    = (MAX_HOLD > 0) && (tmr_q == HOLD_END) && others;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      ST_IDLE: start = arb_vld;
      ST_ENGAGE: begin
        if (!holder_req) rel = 1'b1;
        else if (tmr_q == TON_END) begin
          state_d = ST_GRANTED;
          gnt_d   = s_q;
          tmr_d   = '0;
        end else tmr_d = tmr_q + 1'b1;
      end
      ST_GRANTED: begin
        // The hold timer saturates so a late competing request preempts at once.
        if (!holder_req) begin
          rel = 1'b1;
`ifdef NEM_PARK_EN
          if (bus.REQ == '0) begin
            rel     = 1'b0;
            state_d = ST_PARKED;
            gnt_d   = '0;
          end
`endif
        end else if (preempt) rel = 1'b1;
        else if (tmr_q != HOLD_END) tmr_d = tmr_q + 1'b1;
      end
      ST_RELEASE: begin
        if (tmr_q == TOFF_END) begin
          if (arb_vld) start = 1'b1;
          else state_d = ST_IDLE;
        end else tmr_d = tmr_q + 1'b1;
      end
`ifdef NEM_PARK_EN
      ST_PARKED: begin
        // Same input coming back reuses the still-closed relay without a new actuation.
        if (arb_vld) begin
          if (arb_win == oh2idx(s_q)) begin
            state_d = ST_GRANTED;
            gnt_d   = s_q;
            tmr_d   = '0;
          end else rel = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        gnt_d   = '0;
      end
    endcase
    if (rel) begin
      state_d = ST_RELEASE;
      s_d     = '0;
      gnt_d   = '0;
      tmr_d   = '0;
    end
    if (start) begin
      state_d = ST_ENGAGE;
      win_d   = arb_win;
      s_d     = onehot(arb_win);
      gnt_d   = '0;
      ptr_d   = arb_win + idx_t'(1);
      tmr_d   = '0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CP) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.S       = s_q;
  assign bus.GNT     = gnt_q;
  assign bus.BUSY    = (state_q != ST_IDLE) && (state_q != ST_PARKED);
  assign bus.ACT_CNT = cnt_q;

  a_sel_onehot: assert property (@(posedge CP) $onehot0(s_q));
  a_gnt_match:  assert property (@(posedge CP) (gnt_q == '0) || (gnt_q == s_q));
endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Bench for nem_ohmux_sel_ctrl: table-driven cycle vectors plus fairness, saturation and reset sequences.
module tb_nem_ohmux_sel_ctrl;
  logic CP = 1'b0;
  logic RN = 1'b0;
  always #5 CP = ~CP;

  nem_ohmux_sel_ctrl_if #(.CNT_W(4))  ifa ();
  nem_ohmux_sel_ctrl_if #(.CNT_W(16)) ifb ();

  nem_ohmux_sel_ctrl #(.T_OFF(3), .T_ON(5), .MAX_HOLD(0), .CNT_W(4)) dut_a (
    .CP(CP), .RN(RN), .bus(ifa)
  );
  nem_ohmux_sel_ctrl #(.T_OFF(3), .T_ON(5), .MAX_HOLD(8), .CNT_W(16)) dut_b (
    .CP(CP), .RN(RN), .bus(ifb)
  );

  typedef struct {
    string      name;
    int         n;
    logic [3:0] req;
    logic [3:0] s;
    logic [3:0] gnt;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   fq[$];
  int   ncheck = 0;
  int   nfail  = 0;

  logic [3:0] last_s [2];
  int         zrun   [2];

  function automatic vec_t V(input string nm, input int n, input logic [3:0] r,
                             input logic [3:0] s, input logic [3:0] g,
                             input logic b, input logic [3:0] c);
    vec_t v;
    v.name = nm; v.n = n; v.req = r; v.s = s; v.gnt = g; v.busy = b; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncheck++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got 0x%0h required 0x%0h", nm, $time, got, exp);
    end
  endtask

  // One clock of DUT A: expected record queued with the stimulus, compared after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    sb.push_back(v);
    ifa.REQ = v.req;
    @(posedge CP); #1;
    e = sb.pop_front();
    chk(e.name, {19'd0, ifa.S, ifa.GNT, ifa.BUSY, ifa.ACT_CNT},
                {19'd0, e.s, e.gnt, e.busy, e.cnt});
  endtask

  // Two different closed selects must be separated by at least T_OFF open cycles.
  task automatic bbm(input int k, input logic [3:0] s);
    if (!RN) begin
      last_s[k] = '0;
      zrun[k]   = 0;
    end else if (s == '0) begin
      zrun[k]++;
    end else begin
      if (last_s[k] != '0 && s != last_s[k])
        chk($sformatf("bbm%0d_gap", k), 32'(zrun[k] >= 3), 32'd1);
      last_s[k] = s;
      zrun[k]   = 0;
    end
  endtask

  always @(negedge CP) begin
    bbm(0, ifa.S);
    bbm(1, ifb.S);
  end

  function automatic int gidx(input logic [3:0] g);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) if (g[k]) r = k;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    int cur;
    int exp_i;
    int c;
    ifa.REQ = '0;
    ifb.REQ = '0;
    repeat (2) @(posedge CP);
    #1;
    chk("rst_a", {19'd0, ifa.S, ifa.GNT, ifa.BUSY, ifa.ACT_CNT}, 32'd0);
    chk("rst_b", {7'd0, ifb.S, ifb.GNT, ifb.BUSY, ifb.ACT_CNT}, 32'd0);
    RN = 1'b1;

    vecs.push_back(V("basic_engage",  1,  4'b0001, 4'b0001, 4'b0000, 1'b1, 4'd1));
    vecs.push_back(V("basic_settle",  4,  4'b0001, 4'b0001, 4'b0000, 1'b1, 4'd1));
    vecs.push_back(V("basic_gnt",     1,  4'b0001, 4'b0001, 4'b0001, 1'b1, 4'd1));
    vecs.push_back(V("hold_no_preempt", 14, 4'b0101, 4'b0001, 4'b0001, 1'b1, 4'd1));
    vecs.push_back(V("handover_open", 3,  4'b0100, 4'b0000, 4'b0000, 1'b1, 4'd1));
    vecs.push_back(V("handover_eng",  5,  4'b0100, 4'b0100, 4'b0000, 1'b1, 4'd2));
    vecs.push_back(V("handover_gnt",  1,  4'b0100, 4'b0100, 4'b0100, 1'b1, 4'd2));
`ifdef NEM_PARK_EN
    vecs.push_back(V("park_enter",    1,  4'b0000, 4'b0100, 4'b0000, 1'b0, 4'd2));
    vecs.push_back(V("park_stay",     2,  4'b0000, 4'b0100, 4'b0000, 1'b0, 4'd2));
    vecs.push_back(V("park_regrant",  1,  4'b0100, 4'b0100, 4'b0100, 1'b1, 4'd2));
    vecs.push_back(V("park_hold",     2,  4'b0100, 4'b0100, 4'b0100, 1'b1, 4'd2));
    vecs.push_back(V("park_again",    1,  4'b0000, 4'b0100, 4'b0000, 1'b0, 4'd2));
    vecs.push_back(V("park_other",    3,  4'b0010, 4'b0000, 4'b0000, 1'b1, 4'd2));
`else
    vecs.push_back(V("drop_open",     3,  4'b0000, 4'b0000, 4'b0000, 1'b1, 4'd2));
    vecs.push_back(V("drop_idle",     1,  4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd2));
`endif
    vecs.push_back(V("abort_engage",  2,  4'b0010, 4'b0010, 4'b0000, 1'b1, 4'd3));
    vecs.push_back(V("abort_open",    3,  4'b0000, 4'b0000, 4'b0000, 1'b1, 4'd3));
    vecs.push_back(V("abort_idle",    1,  4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd3));
    vecs.push_back(V("multi_engage",  1,  4'b1010, 4'b1000, 4'b0000, 1'b1, 4'd4));
    vecs.push_back(V("multi_settle",  4,  4'b1010, 4'b1000, 4'b0000, 1'b1, 4'd4));
    vecs.push_back(V("multi_gnt",     1,  4'b1010, 4'b1000, 4'b1000, 1'b1, 4'd4));
    vecs.push_back(V("multi_open",    3,  4'b0010, 4'b0000, 4'b0000, 1'b1, 4'd4));
    vecs.push_back(V("multi_next",    5,  4'b0010, 4'b0010, 4'b0000, 1'b1, 4'd5));
    vecs.push_back(V("multi_gnt2",    1,  4'b0010, 4'b0010, 4'b0010, 1'b1, 4'd5));
`ifdef NEM_PARK_EN
    vecs.push_back(V("final_park",    1,  4'b0000, 4'b0010, 4'b0000, 1'b0, 4'd5));
`else
    vecs.push_back(V("final_open",    3,  4'b0000, 4'b0000, 4'b0000, 1'b1, 4'd5));
    vecs.push_back(V("final_idle",    1,  4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd5));
`endif

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].n; r++) step(vecs[i]);
    end

    // Saturation: 16 aborted engagements, then a 17th that reaches GRANTED.
    RN = 1'b0;
    step(V("sat_rst", 1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd0));
    RN = 1'b1;
    for (int k = 0; k < 16; k++) begin
      c = (k + 1 > 15) ? 15 : k + 1;
      step(V("sat_engage", 1, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'(c)));
      for (int r = 0; r < 3; r++)
        step(V("sat_open", 1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'(c)));
      step(V("sat_idle", 1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'(c)));
    end
    step(V("sat_last", 1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'd15));
    for (int r = 0; r < 4; r++)
      step(V("sat_settle", 1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'd15));
    step(V("sat_gnt", 1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 4'd15));

    RN = 1'b0;
    step(V("rst_mid_granted", 1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'd0));
    RN = 1'b1;
    step(V("ptr_after_rst", 1, 4'b1100, 4'b0100, 4'b0000, 1'b1, 4'd1));
    ifa.REQ = '0;

    // Fairness with preemption on DUT B: all four requests held.
    for (int k = 0; k < 5; k++) fq.push_back(k % 4);
    ifb.REQ = 4'b1111;
    run = 0;
    cur = -1;
    for (int cyc = 0; cyc < 400 && fq.size() > 0; cyc++) begin
      @(posedge CP); #1;
      if (ifb.GNT != '0) begin
        cur = gidx(ifb.GNT);
        run++;
      end else if (run > 0) begin
        exp_i = fq.pop_front();
        chk("fair_order", 32'(cur), 32'(exp_i));
        chk("fair_len", 32'(run), 32'd8);
        run = 0;
      end
    end
    if (fq.size() > 0) chk("fair_timeout", 32'(fq.size()), 32'd0);
    ifb.REQ = '0;
    repeat (2) @(posedge CP);

    $display("%0d/%0d checks passed", ncheck - nfail, ncheck);
    $finish;
  end
endmodule

// File: doc/nem_ohmux_sel_ctrl.md
Name: nem_ohmux_sel_ctrl

Overview:
- Select sequencer and arbiter for the 4-input, 8-bit NEM one-hot inverting mux.
- Shares the mux between 4 requesters using round-robin arbitration.
- Drives the one-hot relay selects S0..S3 with break-before-make timing, so two relays are never closed at once.
- Grants data use only after the relay pull-in settle time; tracks relay actuation count for endurance monitoring.

Parameters:
- T_OFF, 3: cycles all selects must be open (pull-out) before any select closes; must be ≥1.
- T_ON, 5: cycles after a select closes before GNT is asserted (pull-in settle); must be ≥1.
- MAX_HOLD, 0: max GRANTED cycles before preemption when another request is pending; 0 disables preemption.
- CNT_W, 16: width of the actuation counter.

Ports:
- CP  in  1  clock, rising edge.
- RN  in  1  synchronous active-low reset.
- REQ  in  4  level request per mux input; the requester holds it high for as long as it needs the mux.
- S  out  4  one-hot relay selects to mux S0..S3; all-zero means open.
- GNT  out  4  one-hot grant; bit i high means input i is closed and settled.
- BUSY  out  1  high in any state other than IDLE (and other than PARKED when the feature is built in).
- ACT_CNT  out  CNT_W  saturating count of select closures.

Behaviour:
- Clock and reset: one clock, CP; reset RN is synchronous, active-low.
- Reset values: S=0, GNT=0, BUSY=0, ACT_CNT=0, state=IDLE, round-robin pointer=0.
- Reset mid-operation opens all selects on the next edge; no T_OFF wait is applied.
- States: IDLE, ENGAGE, GRANTED, RELEASE.
- IDLE, REQ≠0: at that edge the winner is latched (round-robin from the pointer), S=onehot(winner), ACT_CNT++, and the state moves to ENGAGE.
- ENGAGE: counts T_ON cycles. GNT rises exactly T_ON edges after S rises, and the state becomes GRANTED.
  - If REQ[winner] drops during ENGAGE: go to RELEASE; S=0 on the next edge; GNT is never asserted.
- GRANTED: GNT=S.
  - REQ[winner] falling → RELEASE. S and GNT drop on the same edge.
  - Preemption (MAX_HOLD>0): if GRANTED has lasted MAX_HOLD cycles and another REQ bit is high → RELEASE.
- RELEASE: S=0 for exactly T_OFF cycles. Then:
  - If REQ≠0: pick a winner and enter ENGAGE, as from IDLE.
  - Otherwise: enter IDLE.
- Round-robin: the pointer moves to winner+1 mod 4 at the ENGAGE entry. A requester whose REQ is held continuously is served within 3 other grants.
- Simultaneous REQ changes in the same cycle resolve only by the pointer order.
- Invariants (assertions):
  - S is zero or one-hot.
  - Between two different non-zero S values there are at least T_OFF consecutive cycles of S=0.
  - GNT is nonzero only when GNT==S.
- Latency from IDLE: REQ sampled at edge 0 → S at edge 0 → GNT at edge T_ON.
- ACT_CNT saturates at all-ones and does not wrap.
- The mux inverts the data; that inversion is the consumer's concern, not this block's.

Optional Feature:
- Macro: NEM_PARK_EN.
- Built in: when the holder drops REQ in GRANTED and no other REQ is pending, the state moves to PARKED.
  - PARKED: S stays closed, GNT=0, BUSY=0.
  - If the round-robin winner equals the parked input: GNT returns on the next edge; no ENGAGE; ACT_CNT unchanged.
  - If the winner is a different input: RELEASE, then ENGAGE.
- Not built in: the holder releasing always passes through RELEASE; S is all-zero whenever IDLE.

Decomposition:
- Package nem_ohmux_pkg: state enum; N_IN=4 constant; one-hot helper function; onehot-to-index function.
- Sub-module nem_rr_arb: 4-way round-robin arbiter with pointer input; combinational, with pointer update by the parent.

Test Plan:
- Basic grant: T_OFF=3, T_ON=5; REQ=0001 at edge 0 → S=0001 at edge 0, GNT=0001 at edge 5, ACT_CNT=1.
- Handover: REQ0 held, REQ2 raised, then REQ0 dropped at edge 20.
  - S=0 on edges 20–22; S=0100 at edge 23; GNT=0100 at edge 28.
  - S never shows two bits set.
- Abort: REQ1 drops 2 cycles into ENGAGE → GNT stays 0; S=0 for 3 cycles; then IDLE, BUSY=0.
- Fairness and preemption: MAX_HOLD=8, REQ=1111 held → grant order 0,1,2,3,0; each GRANTED lasts 8 cycles.
- Saturation: CNT_W=4, 17 engagements → ACT_CNT=15. RN low mid-GRANTED → S=GNT=0 next edge, ACT_CNT=0.
- NEM_PARK_EN: REQ0 released and re-asserted → GNT=0001 one edge later; S stays 0001 throughout; ACT_CNT unchanged.
